// File: rtl/apb_master_pkg.sv
// Shared types and default sizing for the APB initiator.
package apb_master_pkg;

  localparam int APB_ADDR_W  = 10;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags when the wait budget is used up.
// TIMEOUT=0 disables expiry; the counter saturates instead of wrapping.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST    = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt;

  // Wait counter: cleared on entry to a transfer, saturating increment otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is judged on the current cycle so the FSM can end ACCESS this edge
  always_comb begin
    expired = 1'b0;
    if (TIMEOUT != 0) expired = (cnt == LAST);
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: command/response handshake in, SETUP/ACCESS transfers out.
// Slave wait states are bounded by apb_wait_timer; expiry returns an error.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  apb_state_t state;
  logic       tmr_expired;

  assign cmd_ready_o = (state == IDLE);

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !pready_i),
    .expired (tmr_expired)
  );

  // Transfer FSM with registered APB and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_o  <= cmd_addr_i;
            pwrite_o <= cmd_write_i;
            // Reads leave pwdata_o untouched to avoid needless bus toggling
            if (cmd_write_i) pwdata_o <= cmd_wdata_i;
            psel_o   <= 1'b1;
            penable_o <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // A late pready takes priority over a timeout in the same cycle
          if (pready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            state       <= IDLE;
          end else if (tmr_expired) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench: DUT a (TIMEOUT=16) talks to a small memory slave with a
// programmable stall; DUT b (TIMEOUT=4) sees a slave that never answers.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic [9:0]  paddr;

  logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_err_b;
  logic        psel_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, pwdata_b;
  logic [9:0]  paddr_b;
  logic [31:0] prdata_b = 32'hA5A5_5A5A;
  logic        pready_b = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
  );

  apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b),
    .psel_o(psel_b), .penable_o(penable_b), .paddr_o(paddr_b), .pwrite_o(pwrite_b),
    .pwdata_o(pwdata_b), .prdata_i(prdata_b), .pready_i(pready_b)
  );

  // Memory slave: pready after 'stall' ACCESS cycles, writes land on completion
  logic [31:0] mem [0:1023];
  int          stall = 0;
  int          acc   = 0;

  always @(posedge clk) begin
    if (reset || (psel && !penable)) acc <= 0;
    else if (psel && penable) acc <= acc + 1;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  assign pready = (acc >= stall);
  assign prdata = mem[paddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid_b = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    tick(); tick();

    // Reset state
    check("rst_psel",    {31'b0, psel},      32'd0);
    check("rst_penable", {31'b0, penable},   32'd0);
    check("rst_paddr",   {22'b0, paddr},     32'd0);
    check("rst_pwdata",  pwdata,             32'd0);
    check("rst_rsp",     {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata",   rsp_rdata,          32'd0);
    check("rst_ready",   {31'b0, cmd_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Write 0x005 <- DEADBEEF, zero waits
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h005; cmd_wdata = 32'hDEADBEEF;
    check("wr_ready_T", {31'b0, cmd_ready}, 32'd1);
    tick();                                   // T+1 SETUP
    cmd_valid = 1'b0; cmd_addr = 10'h3FF; cmd_wdata = 32'h0;
    check("wr_setup_sel", {30'b0, psel, penable}, 32'd2);
    check("wr_setup_rdy", {31'b0, cmd_ready}, 32'd0);
    check("wr_paddr",  {22'b0, paddr}, 32'h005);
    check("wr_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_pwrite", {31'b0, pwrite}, 32'd1);
    tick();                                   // T+2 ACCESS
    check("wr_access", {30'b0, psel, penable}, 32'd3);
    check("wr_norsp",  {31'b0, rsp_valid}, 32'd0);
    tick();                                   // T+3 response
    check("wr_rsp",    {30'b0, rsp_valid, rsp_err}, 32'd2);
    check("wr_rdata",  rsp_rdata, 32'd0);
    check("wr_idle",   {30'b0, psel, penable}, 32'd0);
    check("wr_rdy_T3", {31'b0, cmd_ready}, 32'd1);
    check("wr_hold_addr", {22'b0, paddr}, 32'h005);
    tick();
    check("wr_pulse", {31'b0, rsp_valid}, 32'd0);

    // Read back 0x005; pwdata must hold the previous write data
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h005; cmd_wdata = 32'h1111_2222;
    tick();
    cmd_valid = 1'b0;
    check("rd_pwrite_s", {31'b0, pwrite}, 32'd0);
    check("rd_pwdata_hold", pwdata, 32'hDEADBEEF);
    tick();
    check("rd_pwrite_a", {31'b0, pwrite}, 32'd0);
    tick();
    check("rd_rsp",   {30'b0, rsp_valid, rsp_err}, 32'd2);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    check("rd_pulse", {31'b0, rsp_valid}, 32'd0);
    check("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Five wait states: ACCESS lasts six cycles with stable bus
    stall = 5;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h007; cmd_wdata = 32'h1234_5678;
    tick();
    cmd_valid = 1'b0; cmd_addr = 10'h000; cmd_wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ws_bus",   {30'b0, psel, penable}, 32'd3);
      check("ws_paddr", {22'b0, paddr}, 32'h007);
      check("ws_pwdata", pwdata, 32'h1234_5678);
      check("ws_norsp", {31'b0, rsp_valid}, 32'd0);
    end
    tick();
    check("ws_rsp", {30'b0, rsp_valid, rsp_err}, 32'd2);
    check("ws_idle", {31'b0, psel}, 32'd0);
    stall = 0;
    tick();

    // Timeout on DUT b: read, slave never ready, TIMEOUT=4
    cmd_valid_b = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h02A;
    tick();
    cmd_valid_b = 1'b0;
    check("to_setup", {30'b0, psel_b, penable_b}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_access", {30'b0, psel_b, penable_b}, 32'd3);
      check("to_norsp",  {31'b0, rsp_valid_b}, 32'd0);
    end
    tick();
    check("to_rsp",   {30'b0, rsp_valid_b, rsp_err_b}, 32'd3);
    check("to_rdata", rsp_rdata_b, 32'd0);
    check("to_psel",  {31'b0, psel_b}, 32'd0);
    tick();
    check("to_pulse", {31'b0, rsp_valid_b}, 32'd0);
    check("to_err_hold", {31'b0, rsp_err_b}, 32'd1);

    // Back-to-back writes with cmd_valid held: SETUP every three cycles
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h001; cmd_wdata = 32'hC0DE_0001;
    for (int k = 0; k < 3; k++) begin
      check("b2b_rdy_accept", {31'b0, cmd_ready}, 32'd1);
      tick();
      check("b2b_setup", {30'b0, psel, penable}, 32'd2);
      check("b2b_rdy_s", {31'b0, cmd_ready}, 32'd0);
      check("b2b_paddr", {22'b0, paddr}, 32'(k + 1));
      tick();
      check("b2b_access", {30'b0, psel, penable}, 32'd3);
      check("b2b_rdy_a", {31'b0, cmd_ready}, 32'd0);
      tick();
      check("b2b_rsp", {30'b0, rsp_valid, rsp_err}, 32'd2);
      check("b2b_rsp_addr", {22'b0, paddr}, 32'(k + 1));
      if (k < 2) begin
        cmd_addr  = 10'(k + 2);
        cmd_wdata = 32'hC0DE_0000 + 32'(k + 2);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check("b2b_mem1", mem[1], 32'hC0DE_0001);
    check("b2b_mem3", mem[3], 32'hC0DE_0003);

    // Reset during ACCESS of a read: no response ever appears
    stall = 10;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h005;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("rr_in_access", {30'b0, psel, penable}, 32'd3);
    reset = 1'b1;
    tick();
    check("rr_bus", {30'b0, psel, penable}, 32'd0);
    check("rr_norsp", {31'b0, rsp_valid}, 32'd0);
    check("rr_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_quiet", {31'b0, rsp_valid}, 32'd0);
      check("rr_ready", {31'b0, cmd_ready}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns a simple command/response handshake into APB SETUP/ACCESS transfers toward an APB slave, such as the memory-backed slave in this codebase.
- Sits between the test/traffic side (command producer) and the APB bus.
- Handles slave wait states (pready low) and bounds them with a programmable timeout that returns an error response.

Parameters:
ADDR_W, 10, APB address width (paddr_o, cmd_addr_i)
DATA_W, 32, APB data width (pwdata_o, prdata_i, cmd_wdata_i, rsp_rdata_o)
TIMEOUT, 16, max ACCESS cycles waiting for pready_i before erroring; 0 disables timeout

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid_i  input  1  command request valid
cmd_ready_o  output  1  master can accept a command
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  transfer address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  one-cycle pulse: transfer completed
rsp_rdata_o  output  DATA_W  read data (0 for writes and on error)
rsp_err_o  output  1  transfer ended by timeout (valid with rsp_valid_o)
psel_o  output  1  APB select
penable_o  output  1  APB enable
paddr_o  output  ADDR_W  APB address
pwrite_o  output  1  APB direction
pwdata_o  output  DATA_W  APB write data
prdata_i  input  DATA_W  APB read data
pready_i  input  1  APB ready

Behaviour:
- Reset (sync, high): state=IDLE; psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, wait counter all 0.
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready_o = (state==IDLE), combinational; no other state accepts commands.
- IDLE: on cmd_valid_i & cmd_ready_o, register addr/write/wdata into paddr_o/pwrite_o/pwdata_o, go to SETUP. pwdata_o is loaded only on writes and holds its old value on reads.
- SETUP (1 cycle): psel_o=1, penable_o=0. Next state is ACCESS. Clear the wait counter.
- ACCESS: psel_o=1, penable_o=1, with paddr_o/pwrite_o/pwdata_o stable.
  - pready_i=1: complete the transfer and go to IDLE.
  - pready_i=0: increment the wait counter and stay in ACCESS.
- Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready_i=0, complete with err and go to IDLE.
- Completion: registered; in the cycle after the completing ACCESS cycle, rsp_valid_o=1 for exactly 1 cycle.
  - rsp_rdata_o = prdata_i sampled on the completing edge for reads, 0 for writes or on timeout.
  - rsp_err_o = 1 only on timeout.
  - rsp_rdata_o/rsp_err_o hold until the next completion.
- After ACCESS, psel_o/penable_o return to 0. paddr_o/pwrite_o/pwdata_o keep their last values (no toggling).
- Latency: accept at edge T → SETUP cycle T+1 → ACCESS T+2. With zero waits, rsp_valid_o is high in cycle T+3, where cmd_ready_o is also high. Back-to-back commands therefore reach SETUP every 3 cycles.
- Wait counter width: $clog2(TIMEOUT+1), minimum 1. It must not wrap when TIMEOUT=0 (saturate).
- A late pready_i in the same cycle the timeout fires: pready wins (normal completion, err=0).
- Reset mid-transfer: next edge forces IDLE with psel_o/penable_o=0. The aborted transfer generates no response.
- cmd_valid_i may drop without acceptance; no command is latched unless valid&ready at the edge.

Decomposition:
- Package apb_master_pkg: state enum typedef (IDLE/SETUP/ACCESS, 2-bit) and default constants APB_ADDR_W=10, APB_DATA_W=32, APB_TIMEOUT=16.
- One natural sub-module, apb_wait_timer: clear/enable inputs, expired output, parameter TIMEOUT, with saturation and disable-at-0 behaviour.

Test Plan:
- Write addr 0x005 data 0xDEADBEEF to a zero-wait slave → psel_o rises T+1, penable_o T+2, rsp_valid_o at T+3 with err=0, rdata=0.
- Read back 0x005 → pwrite_o=0 throughout, rsp_rdata_o=0xDEADBEEF, err=0, single-cycle rsp_valid_o.
- Slave holds pready_i low 5 ACCESS cycles (TIMEOUT=16) → ACCESS lasts 6 cycles, paddr_o/pwdata_o/psel_o/penable_o stable throughout, rsp ok.
- pready_i never asserted, TIMEOUT=4 → exactly 4 ACCESS cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, psel_o=0.
- cmd_valid_i held high with writes to 0x001, 0x002, 0x003 back-to-back → SETUP every 3 cycles, three responses in order, cmd_ready_o low during SETUP/ACCESS.
- Assert reset during ACCESS of a read → next cycle psel_o=penable_o=0, rsp_valid_o never pulses, cmd_ready_o=1 after reset release.
